// File: rtl/ppu_pixel_mux_if.sv
// Bundle of the pixel-mux data and CPU palette buses. The render path is a
// free-running pipeline: no valid/ready handshake, one dot accepted every clock.
interface ppu_pixel_mux_if;
    logic [9:0] x_idx;
    logic [9:0] scanline;
    logic [3:0] bg_pixel;
    logic [3:0] spr_pixel;
    logic       spr_priority;
    logic       spr_zero;
    logic       show_bg;
    logic       show_spr;
    logic       show_bg_left;
    logic       show_spr_left;
    logic       grayscale;
    logic       clear_flags;
    logic       pal_we;
    logic [4:0] pal_addr;
    logic [5:0] pal_wdata;
    logic [5:0] pal_rdata;
    logic [5:0] color_idx;
    logic       pixel_valid;
    logic [7:0] pixel_x;
    logic [7:0] pixel_y;
    logic       sprite0_hit;

    modport master (
        output x_idx, scanline, bg_pixel, spr_pixel, spr_priority, spr_zero,
               show_bg, show_spr, show_bg_left, show_spr_left, grayscale,
               clear_flags, pal_we, pal_addr, pal_wdata,
        input  pal_rdata, color_idx, pixel_valid, pixel_x, pixel_y, sprite0_hit
    );

    modport slave (
        input  x_idx, scanline, bg_pixel, spr_pixel, spr_priority, spr_zero,
               show_bg, show_spr, show_bg_left, show_spr_left, grayscale,
               clear_flags, pal_we, pal_addr, pal_wdata,
        output pal_rdata, color_idx, pixel_valid, pixel_x, pixel_y, sprite0_hit
    );
endinterface

// File: rtl/ppu_pixel_mux.sv
// PPU background/sprite priority mux with 32x6 palette RAM and sprite-0 hit.
// Two-stage pipeline: stage 1 picks the palette address, stage 2 reads the RAM.
module ppu_pixel_mux (
    input  logic             clk,
    input  logic             reset,
    ppu_pixel_mux_if.slave   bus
);

    logic [5:0] pal_ram [32];

    logic       visible;
    logic       bg_clip;
    logic       spr_clip;
    logic       bg_opaque;
    logic       spr_opaque;
    logic [4:0] mux_addr;
    logic [4:0] render_idx;
    logic [4:0] cpu_idx;
    logic       hit_set;

    logic       s1_valid;
    logic       s1_gray;
    logic [4:0] s1_addr;
    logic [7:0] s1_x;
    logic [7:0] s1_y;

    // Sprite-palette backdrop slots $10/$14/$18/$1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] a);
        pal_mirror = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

    always_comb begin
        visible    = (bus.x_idx < 10'd256) && (bus.scanline >= 10'd1) &&
                     (bus.scanline <= 10'd240);
        bg_clip    = (bus.x_idx < 10'd8) && !bus.show_bg_left;
        spr_clip   = (bus.x_idx < 10'd8) && !bus.show_spr_left;
        bg_opaque  = bus.show_bg && (bus.bg_pixel[1:0] != 2'b00) && !bg_clip;
        spr_opaque = bus.show_spr && (bus.spr_pixel[1:0] != 2'b00) && !spr_clip;

        mux_addr = 5'h00;
        if (bg_opaque && spr_opaque) begin
            mux_addr = bus.spr_priority ? {1'b0, bus.bg_pixel} : {1'b1, bus.spr_pixel};
        end else if (bg_opaque) begin
            mux_addr = {1'b0, bus.bg_pixel};
        end else if (spr_opaque) begin
            mux_addr = {1'b1, bus.spr_pixel};
        end

        render_idx = pal_mirror(mux_addr);
        cpu_idx    = pal_mirror(bus.pal_addr);
        // Dot 255 never reports a hit, independent of sprite priority.
        hit_set    = visible && bus.spr_zero && bg_opaque && spr_opaque &&
                     (bus.x_idx != 10'd255);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                pal_ram[i] <= 6'h00;
            end
            s1_valid        <= 1'b0;
            s1_gray         <= 1'b0;
            s1_addr         <= 5'h00;
            s1_x            <= 8'h00;
            s1_y            <= 8'h00;
            bus.pal_rdata   <= 6'h00;
            bus.color_idx   <= 6'h00;
            bus.pixel_valid <= 1'b0;
            bus.pixel_x     <= 8'h00;
            bus.pixel_y     <= 8'h00;
            bus.sprite0_hit <= 1'b0;
        end else begin
            // Reads below see the RAM before this edge's write lands.
            if (bus.pal_we) begin
                pal_ram[cpu_idx] <= bus.pal_wdata;
            end
            bus.pal_rdata <= pal_ram[cpu_idx];

            s1_valid <= visible;
            s1_gray  <= bus.grayscale;
            s1_addr  <= render_idx;
            s1_x     <= bus.x_idx[7:0];
            s1_y     <= bus.scanline[7:0] - 8'd1;

            bus.pixel_valid <= s1_valid;
            bus.color_idx   <= s1_valid ?
                               (pal_ram[s1_addr] & (s1_gray ? 6'h30 : 6'h3F)) : 6'h00;
            bus.pixel_x     <= s1_x;
            bus.pixel_y     <= s1_y;

            if (bus.clear_flags) begin
                bus.sprite0_hit <= 1'b0;
            end else if (hit_set) begin
                bus.sprite0_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Bench for ppu_pixel_mux: constant vector table, hand sequences for the
// multi-cycle corners, and random traffic against a behavioural model.
module tb_ppu_pixel_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ppu_pixel_mux_if bus ();

    ppu_pixel_mux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [5:0]  m_ram [32];
    logic        m_hit;
    logic        p1_valid;
    logic        p1_gray;
    logic [4:0]  p1_addr;
    logic [7:0]  p1_x;
    logic [7:0]  p1_y;
    // {hit, rdata[5:0], valid, x[7:0], y[7:0], color[5:0]}
    logic [29:0] exp_q [$];

    typedef struct {
        logic [3:0] bg;
        logic [3:0] spr;
        logic       prio;
        logic       sbg;
        logic       sspr;
        logic       sbgl;
        logic       ssprl;
        logic       gray;
        logic [9:0] x;
        logic [9:0] line;
        logic [5:0] color;
        logic       valid;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] mir(input logic [4:0] a);
        if (a >= 5'd16 && (a % 4) == 0) return a - 5'd16;
        return a;
    endfunction

    // One clock: model predicts the post-edge outputs, then compare after the edge.
    task automatic step();
        logic [29:0] e;
        logic        vis;
        logic        bg_on;
        logic        spr_on;
        logic [4:0]  a;
        int          x;
        int          ln;
        x  = int'(bus.x_idx);
        ln = int'(bus.scanline);
        if (!reset) begin
            e = '0;
            for (int i = 0; i < 32; i++) m_ram[i] = 6'h00;
            m_hit = 1'b0; p1_valid = 1'b0; p1_gray = 1'b0;
            p1_addr = 5'h00; p1_x = 8'h00; p1_y = 8'h00;
        end else begin
            e[22:0]  = {p1_valid, p1_x, p1_y,
                        p1_valid ? (m_ram[p1_addr] & (p1_gray ? 6'h30 : 6'h3F)) : 6'h00};
            e[28:23] = m_ram[mir(bus.pal_addr)];
            vis    = (x < 256) && (ln >= 1) && (ln <= 240);
            bg_on  = bus.show_bg && (bus.bg_pixel % 4 != 0) && !(x < 8 && !bus.show_bg_left);
            spr_on = bus.show_spr && (bus.spr_pixel % 4 != 0) && !(x < 8 && !bus.show_spr_left);
            if (bg_on && spr_on) a = bus.spr_priority ? 5'(bus.bg_pixel) : 5'(bus.spr_pixel) + 5'd16;
            else if (bg_on)      a = 5'(bus.bg_pixel);
            else if (spr_on)     a = 5'(bus.spr_pixel) + 5'd16;
            else                 a = 5'd0;
            if (bus.clear_flags) m_hit = 1'b0;
            else if (vis && bus.spr_zero && bg_on && spr_on && x != 255) m_hit = 1'b1;
            e[29] = m_hit;
            if (bus.pal_we) m_ram[mir(bus.pal_addr)] = bus.pal_wdata;
            p1_valid = vis;
            p1_gray  = bus.grayscale;
            p1_addr  = mir(a);
            p1_x     = 8'(x);
            p1_y     = 8'(ln - 1);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pixel_valid", 32'(bus.pixel_valid), 32'(e[22]));
        chk("color_idx", 32'(bus.color_idx), 32'(e[5:0]));
        if (e[22]) begin
            chk("pixel_x", 32'(bus.pixel_x), 32'(e[21:14]));
            chk("pixel_y", 32'(bus.pixel_y), 32'(e[13:6]));
        end
        chk("pal_rdata", 32'(bus.pal_rdata), 32'(e[28:23]));
        chk("sprite0_hit", 32'(bus.sprite0_hit), 32'(e[29]));
    endtask

    task automatic idle();
        bus.x_idx = 10'd300; bus.scanline = 10'd0;
        bus.bg_pixel = 4'h0; bus.spr_pixel = 4'h0; bus.spr_priority = 1'b0;
        bus.spr_zero = 1'b0; bus.grayscale = 1'b0;
        bus.clear_flags = 1'b0; bus.pal_we = 1'b0;
    endtask

    task automatic set_dot(input logic [9:0] x, input logic [9:0] line,
                           input logic [3:0] bg, input logic [3:0] spr);
        bus.x_idx = x; bus.scanline = line; bus.bg_pixel = bg; bus.spr_pixel = spr;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        bus.pal_we = 1'b1; bus.pal_addr = a; bus.pal_wdata = d;
        step();
        bus.pal_we = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd20,  10'd10,  6'h16, 1'b1};
        vecs[1]  = '{4'h1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd50,  10'd5,   6'h27, 1'b1};
        vecs[2]  = '{4'h1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd50,  10'd5,   6'h11, 1'b1};
        vecs[3]  = '{4'h4, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd60,  10'd5,   6'h0F, 1'b1};
        vecs[4]  = '{4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd3,   10'd5,   6'h0F, 1'b1};
        vecs[5]  = '{4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd3,   10'd5,   6'h11, 1'b1};
        vecs[6]  = '{4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd70,  10'd7,   6'h20, 1'b1};
        vecs[7]  = '{4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd300, 10'd7,   6'h00, 1'b0};
        vecs[8]  = '{4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd20,  10'd0,   6'h00, 1'b0};
        vecs[9]  = '{4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd20,  10'd241, 6'h00, 1'b0};
        vecs[10] = '{4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd255, 10'd240, 6'h16, 1'b1};
        vecs[11] = '{4'h0, 4'hD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd9,   10'd1,   6'h35, 1'b1};
        vecs[12] = '{4'h1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd4,   10'd1,   6'h11, 1'b1};
        vecs[13] = '{4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd30,  10'd30,  6'h0F, 1'b1};
        vecs[14] = '{4'h3, 4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd30,  10'd30,  6'h27, 1'b1};

        reset = 1'b0;
        bus.pal_addr = 5'h00; bus.pal_wdata = 6'h00;
        bus.show_bg = 1'b1; bus.show_spr = 1'b1;
        bus.show_bg_left = 1'b1; bus.show_spr_left = 1'b1;
        idle();
        step();
        step();
        chk("rst_color", 32'(bus.color_idx), 32'h0);
        chk("rst_valid", 32'(bus.pixel_valid), 32'h0);
        chk("rst_hit", 32'(bus.sprite0_hit), 32'h0);
        chk("rst_rdata", 32'(bus.pal_rdata), 32'h0);
        reset = 1'b1;

        pal_write(5'h00, 6'h0F);
        pal_write(5'h01, 6'h11);
        pal_write(5'h03, 6'h16);
        pal_write(5'h05, 6'h2A);
        pal_write(5'h16, 6'h27);
        pal_write(5'h1D, 6'h35);

        foreach (vecs[i]) begin
            set_dot(vecs[i].x, vecs[i].line, vecs[i].bg, vecs[i].spr);
            bus.spr_priority = vecs[i].prio; bus.show_bg = vecs[i].sbg;
            bus.show_spr = vecs[i].sspr; bus.show_bg_left = vecs[i].sbgl;
            bus.show_spr_left = vecs[i].ssprl; bus.grayscale = vecs[i].gray;
            step();
            idle();
            step();
            chk("tbl_color", 32'(bus.color_idx), 32'(vecs[i].color));
            chk("tbl_valid", 32'(bus.pixel_valid), 32'(vecs[i].valid));
            if (i == 0) begin
                chk("tbl_x", 32'(bus.pixel_x), 32'd20);
                chk("tbl_y", 32'(bus.pixel_y), 32'd9);
            end
        end
        bus.show_bg = 1'b1; bus.show_spr = 1'b1;
        bus.show_bg_left = 1'b1; bus.show_spr_left = 1'b1;

        // Mirrored write of $10 lands in $00 and becomes the backdrop.
        pal_write(5'h10, 6'h21);
        bus.pal_addr = 5'h00;
        step();
        chk("mirror_rd", 32'(bus.pal_rdata), 32'h21);
        set_dot(10'd40, 10'd40, 4'h4, 4'h0);
        step();
        idle();
        step();
        chk("backdrop", 32'(bus.color_idx), 32'h21);

        // Same-cycle write vs render and CPU read of entry $03.
        set_dot(10'd41, 10'd40, 4'h3, 4'h0);
        step();
        idle();
        pal_write(5'h03, 6'h3A);
        chk("wr_old_render", 32'(bus.color_idx), 32'h16);
        chk("wr_old_cpu", 32'(bus.pal_rdata), 32'h16);
        step();
        chk("wr_new_cpu", 32'(bus.pal_rdata), 32'h3A);

        // Sprite-0 hit: excluded dots, set, hold, clear priority.
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        chk("hit_clear0", 32'(bus.sprite0_hit), 32'h0);
        set_dot(10'd255, 10'd50, 4'h3, 4'h1);
        bus.spr_zero = 1'b1;
        step();
        chk("hit_x255", 32'(bus.sprite0_hit), 32'h0);
        set_dot(10'd3, 10'd50, 4'h3, 4'h1);
        bus.show_bg_left = 1'b0;
        step();
        chk("hit_clip", 32'(bus.sprite0_hit), 32'h0);
        bus.show_bg_left = 1'b1;
        set_dot(10'd100, 10'd50, 4'h3, 4'h1);
        step();
        chk("hit_set", 32'(bus.sprite0_hit), 32'h1);
        idle();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hit_hold", 32'(bus.sprite0_hit), 32'h1);
        end
        set_dot(10'd100, 10'd50, 4'h3, 4'h1);
        bus.spr_zero = 1'b1; bus.clear_flags = 1'b1;
        step();
        chk("hit_clear_wins", 32'(bus.sprite0_hit), 32'h0);
        bus.clear_flags = 1'b0; bus.spr_priority = 1'b1;
        step();
        chk("hit_behind", 32'(bus.sprite0_hit), 32'h1);

        // Reset mid-line with hit set and RAM written.
        bus.spr_zero = 1'b0; bus.spr_priority = 1'b0; bus.pal_addr = 5'h03;
        set_dot(10'd120, 10'd60, 4'h3, 4'h0);
        step();
        set_dot(10'd121, 10'd60, 4'h3, 4'h0);
        step();
        reset = 1'b0;
        set_dot(10'd122, 10'd60, 4'h3, 4'h0);
        step();
        chk("mid_rst_valid", 32'(bus.pixel_valid), 32'h0);
        chk("mid_rst_hit", 32'(bus.sprite0_hit), 32'h0);
        chk("mid_rst_color", 32'(bus.color_idx), 32'h0);
        reset = 1'b1;
        set_dot(10'd123, 10'd60, 4'h3, 4'h0);
        step();
        chk("post_rst_valid1", 32'(bus.pixel_valid), 32'h0);
        chk("post_rst_rdata", 32'(bus.pal_rdata), 32'h0);
        set_dot(10'd124, 10'd60, 4'h3, 4'h0);
        step();
        chk("post_rst_valid2", 32'(bus.pixel_valid), 32'h1);
        chk("post_rst_x", 32'(bus.pixel_x), 32'd123);
        chk("post_rst_color", 32'(bus.color_idx), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 149) != 0);
            bus.x_idx = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 255))
                                                    : 10'($urandom_range(256, 340));
            bus.scanline = 10'($urandom_range(0, 261));
            bus.bg_pixel = 4'($urandom); bus.spr_pixel = 4'($urandom);
            bus.spr_priority = 1'($urandom); bus.spr_zero = ($urandom_range(0, 2) == 0);
            bus.show_bg = ($urandom_range(0, 4) != 0); bus.show_spr = ($urandom_range(0, 4) != 0);
            bus.show_bg_left = 1'($urandom); bus.show_spr_left = 1'($urandom);
            bus.grayscale = ($urandom_range(0, 7) == 0);
            bus.clear_flags = ($urandom_range(0, 29) == 0);
            bus.pal_we = ($urandom_range(0, 3) == 0);
            bus.pal_addr = 5'($urandom); bus.pal_wdata = 6'($urandom);
            step();
        end
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ppu_pixel_mux.md
PPU_PIXEL_MUX -- requirements
Module: ppu_pixel_mux

Interface
REQ-001 clk  in  1  PPU pixel clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-low; sampled on rising edge of clk.
REQ-003 x_idx  in  10  current dot, same timebase as the background fetch stage.
REQ-004 scanline  in  10  current scanline; visible lines are 1..240.
REQ-005 bg_pixel  in  4  background palette address {AT_hi, AT_lo, PT_hi, PT_lo} for this dot.
REQ-006 spr_pixel  in  4  sprite palette address {pal_hi, pal_lo, pat_hi, pat_lo}.
REQ-007 spr_priority  in  1  1 = sprite behind background.
REQ-008 spr_zero  in  1  spr_pixel originates from OAM sprite 0.
REQ-009 show_bg, show_spr, show_bg_left, show_spr_left, grayscale  in  1 each  PPUMASK bits.
REQ-010 clear_flags  in  1  one-cycle pulse at pre-render line; clears sprite0_hit.
REQ-011 pal_we  in  1  CPU palette write strobe.
REQ-012 pal_addr  in  5  CPU palette address ($3F00-$3F1F low bits).
REQ-013 pal_wdata  in  6  CPU palette write data.
REQ-014 pal_rdata  out  6  CPU palette read data, registered.
REQ-015 color_idx  out  6  NES master-palette colour for the output pixel.
REQ-016 pixel_valid  out  1  color_idx belongs to a visible dot.
REQ-017 pixel_x  out  8 / pixel_y  out  8  coordinates of the dot on color_idx (pixel_y = scanline-1).
REQ-018 sprite0_hit  out  1  sticky sprite-0 hit flag (PPUSTATUS bit 6).

Function
REQ-019 Visible dot SHALL mean x_idx < 256 and 1 <= scanline <= 240.
REQ-020 Left clip: for x_idx < 8, bg SHALL be treated transparent if show_bg_left=0; sprite transparent if show_spr_left=0.
REQ-021 bg_opaque = show_bg and bg_pixel[1:0] != 0 and not clipped; spr_opaque likewise with show_spr and spr_pixel.
REQ-022 Palette address SHALL be: neither opaque -> 5'h00; bg only -> {0,bg_pixel}; spr only -> {1,spr_pixel}; both -> spr_priority ? {0,bg_pixel} : {1,spr_pixel}.
REQ-023 Stage 1 (cycle N+1) SHALL register palette address, visible flag, x, y; stage 2 (cycle N+2) SHALL register RAM data onto color_idx; latency exactly 2 cycles, one dot per cycle, no stalls.
REQ-024 Palette RAM SHALL be 32 x 6 bits, implemented as registers, with one write port (CPU) and two read ports (render, CPU).
REQ-025 Mirroring: any address with addr[4]=1 and addr[1:0]=0 SHALL map to addr[4]=0, for writes, CPU reads and render reads.
REQ-026 Write SHALL take effect at the clock edge where pal_we=1; a render or CPU read of the same entry in that cycle SHALL return the old value.
REQ-027 pal_rdata SHALL equal RAM[mirror(pal_addr)] one cycle after pal_addr is presented, independent of pal_we.
REQ-028 grayscale=1 (sampled at stage 1) SHALL force color_idx = RAM data & 6'h30.
REQ-029 Non-visible dots SHALL give pixel_valid=0 and color_idx=6'h00 at stage 2.
REQ-030 sprite0_hit SHALL set at stage 1 when visible, spr_zero=1, bg_opaque, spr_opaque, and x_idx != 255, regardless of spr_priority.
REQ-031 sprite0_hit SHALL remain 1 until clear_flags=1 or reset; clear_flags SHALL win over a simultaneous set.
REQ-032 PPUMASK inputs SHALL be used as sampled in the same cycle as the dot; mid-line changes affect subsequent dots only.

Reset
REQ-033 With reset=0 at a clock edge: color_idx, pal_rdata, pixel_x, pixel_y = 0; pixel_valid, sprite0_hit = 0; all 32 RAM entries = 0; pipeline stages invalid.
REQ-034 Reset asserted mid-line SHALL discard in-flight dots; first valid output appears 2 cycles after the first visible dot following deassertion.

Verification
REQ-035 Write RAM[5'h03]=6'h16, RAM[5'h00]=6'h0F; bg_pixel=4'h3, show_bg=1, x=20, line=10 -> color_idx=6'h16, pixel_x=20, pixel_y=9, pixel_valid=1 two cycles later.
REQ-036 Write RAM[5'h10]=6'h21 -> CPU read of 5'h00 returns 6'h21; bg_pixel=4'h4 (transparent) renders 6'h21 backdrop.
REQ-037 bg_pixel=4'h1, spr_pixel=4'h6 opaque: spr_priority=0 -> RAM[5'h16]; spr_priority=1 -> RAM[5'h01].
REQ-038 spr_zero=1, both opaque at x=100 -> sprite0_hit=1 next cycle, held through line end; same at x=255 or x=3 with show_bg_left=0 -> stays 0; clear_flags with hit -> 0.
REQ-039 grayscale=1 with RAM entry 6'h2A -> color_idx=6'h20; x_idx=300 -> pixel_valid=0, color_idx=0.
REQ-040 Assert reset for one cycle during visible line after hit set and RAM written -> all outputs 0, RAM reads 0, valid resumes per REQ-034.
